// File: rtl/div2_engine.sv
// div2_engine: Start/Ack responder that loads a 16-bit dividend and 8-bit
// divisor from data memory, runs a restoring divide, writes a 24-bit quotient.
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous active-low reset
//   Start      host level; a 1->0 transition launches a run, a rise aborts it
//   Ack        run complete, result in memory
//   Busy       engine owns the memory port (all states but IDLE/DONE)
//   MemAddr    data-memory byte address
//   MemRdData  combinational read data for MemAddr
//   MemWrEn    write strobe, memory writes on rising Clk
//   MemWrData  write data
module div2_engine #(
    parameter logic [7:0] OP_BASE  = 8'd0,
    parameter logic [7:0] RES_BASE = 8'd4,
    parameter bit         ROUND    = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic       Busy,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemRdData,
    output logic       MemWrEn,
    output logic [7:0] MemWrData
);

    typedef enum logic [3:0] {
        IDLE, LD0, LD1, LD2, DIV, WR0, WR1, WR2, DONE
    } state_t;

    // Index of the final DIV iteration; the extra one yields the round bit.
    localparam logic [4:0] LAST = ROUND ? 5'd24 : 5'd23;

    state_t      state;
    state_t      state_n;
    logic        start_q;
    logic [23:0] num;
    logic [7:0]  dvs;
    logic [7:0]  rem;
    logic [23:0] quo;
    logic [4:0]  cnt;

    logic        launch;
    logic [8:0]  shifted;
    logic [8:0]  diff;
    logic        take;
    logic [7:0]  rem_n;

    assign launch = !Start && start_q;

    // One restoring step. The remainder is always below the divisor, so
    // both the restored and the subtracted value fit in 8 bits.
    always_comb begin
        shifted = {rem, num[23]};
        diff    = shifted - {1'b0, dvs};
        take    = shifted >= {1'b0, dvs};
        rem_n   = take ? diff[7:0] : shifted[7:0];
    end

    // Moore decode of the memory port; nothing here depends on Start.
    always_comb begin
        Busy      = 1'b0;
        MemAddr   = 8'd0;
        MemWrEn   = 1'b0;
        MemWrData = 8'd0;
        unique case (state)
            LD0: begin
                Busy    = 1'b1;
                MemAddr = OP_BASE;
            end
            LD1: begin
                Busy    = 1'b1;
                MemAddr = OP_BASE + 8'd1;
            end
            LD2: begin
                Busy    = 1'b1;
                MemAddr = OP_BASE + 8'd2;
            end
            DIV: begin
                Busy = 1'b1;
            end
            WR0: begin
                Busy      = 1'b1;
                MemAddr   = RES_BASE;
                MemWrEn   = 1'b1;
                MemWrData = quo[23:16];
            end
            WR1: begin
                Busy      = 1'b1;
                MemAddr   = RES_BASE + 8'd1;
                MemWrEn   = 1'b1;
                MemWrData = quo[15:8];
            end
            WR2: begin
                Busy      = 1'b1;
                MemAddr   = RES_BASE + 8'd2;
                MemWrEn   = 1'b1;
                MemWrData = quo[7:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (launch) state_n = LD0;
            LD0:  state_n = LD1;
            LD1:  state_n = LD2;
            LD2:  state_n = (MemRdData == 8'd0) ? WR0 : DIV;
            DIV:  if (cnt == LAST) state_n = WR0;
            WR0:  state_n = WR1;
            WR1:  state_n = WR2;
            WR2:  state_n = DONE;
            DONE: if (Start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A rising Start while busy abandons the run.
        if (Busy && Start) state_n = IDLE;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            Ack     <= 1'b0;
            num     <= '0;
            dvs     <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            start_q <= Start;
            Ack     <= (state_n == DONE);
            case (state)
                LD0: num <= {MemRdData, 16'h0000};
                LD1: num[15:8] <= MemRdData;
                LD2: begin
                    dvs <= MemRdData;
                    rem <= '0;
                    cnt <= '0;
                    // Zero divisor saturates and skips the divide.
                    quo <= (MemRdData == 8'd0) ? 24'hFFFFFF : 24'h000000;
                end
                DIV: begin
                    num <= {num[22:0], 1'b0};
                    rem <= rem_n;
                    cnt <= cnt + 5'd1;
                    // The round iteration adds its bit instead of shifting.
                    if (ROUND && cnt == LAST)
                        quo <= quo + {23'd0, take};
                    else
                        quo <= {quo[22:0], take};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div2_engine.sv
// tb_div2_engine: drives a truncating and a rounding div2_engine side by side,
// each with its own data memory, and checks results against 64-bit arithmetic.
module tb_div2_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       ack0, busy0, we0;
    logic       ack1, busy1, we1;
    logic [7:0] addr0, rd0, wd0;
    logic [7:0] addr1, rd1, wd1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    int         wr0;
    int         wr1;

    int vectors;
    int miscompares;

    assign rd0 = mem0[addr0];
    assign rd1 = mem1[addr1];

    always @(posedge clk) begin
        if (we0) begin
            mem0[addr0] <= wd0;
            wr0 = wr0 + 1;
        end
        if (we1) begin
            mem1[addr1] <= wd1;
            wr1 = wr1 + 1;
        end
    end

    div2_engine #(.OP_BASE(8'd0), .RES_BASE(8'd4), .ROUND(1'b0)) u0 (
        .Clk(clk), .Reset(rst_n), .Start(start),
        .Ack(ack0), .Busy(busy0),
        .MemAddr(addr0), .MemRdData(rd0),
        .MemWrEn(we0), .MemWrData(wd0)
    );

    div2_engine #(.OP_BASE(8'd0), .RES_BASE(8'd4), .ROUND(1'b1)) u1 (
        .Clk(clk), .Reset(rst_n), .Start(start),
        .Ack(ack1), .Busy(busy1),
        .MemAddr(addr1), .MemRdData(rd1),
        .MemWrEn(we1), .MemWrData(wd1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_q(input logic [15:0] dvd,
                                          input logic [7:0] dvs,
                                          input bit rnd);
        logic [63:0] num;
        logic [63:0] q;
        if (dvs == 8'd0) return 24'hFFFFFF;
        num = {dvd, 48'd0};
        q   = num / {56'd0, dvs};
        return q[63:40] + (rnd ? {23'd0, q[39]} : 24'd0);
    endfunction

    function automatic logic [23:0] res0();
        return {mem0[4], mem0[5], mem0[6]};
    endfunction

    function automatic logic [23:0] res1();
        return {mem1[4], mem1[5], mem1[6]};
    endfunction

    task automatic preload(input logic [15:0] dvd, input logic [7:0] dvs);
        mem0[0] = dvd[15:8]; mem1[0] = dvd[15:8];
        mem0[1] = dvd[7:0];  mem1[1] = dvd[7:0];
        mem0[2] = dvs;       mem1[2] = dvs;
        for (int a = 4; a < 7; a++) begin
            mem0[a] = 8'hA5;
            mem1[a] = 8'hA5;
        end
    endtask

    task automatic run(input logic [15:0] dvd, input logic [7:0] dvs);
        int lat0;
        int lat1;
        @(negedge clk);
        start = 1'b1;
        preload(dvd, dvs);
        repeat (2) @(negedge clk);
        wr0 = 0;
        wr1 = 0;
        start = 1'b0;
        @(posedge clk);
        lat0 = -1;
        lat1 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (ack0 && lat0 < 0) lat0 = c;
            if (ack1 && lat1 < 0) lat1 = c;
        end
        chk("lat_trunc", lat0, (dvs == 0) ? 6 : 30);
        chk("lat_round", lat1, (dvs == 0) ? 6 : 31);
        chk("res_trunc", {8'd0, res0()}, {8'd0, ref_q(dvd, dvs, 1'b0)});
        chk("res_round", {8'd0, res1()}, {8'd0, ref_q(dvd, dvs, 1'b1)});
        chk("wr_trunc", wr0, 3);
        chk("wr_round", wr1, 3);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_clear", {ack0, ack1}, 2'b00);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr0         = 0;
        wr1         = 0;
        for (int a = 0; a < 256; a++) begin
            mem0[a] = 8'h00;
            mem1[a] = 8'h00;
        end
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("reset_out0", {ack0, busy0, we0, addr0, wd0}, 0);
        chk("reset_out1", {ack1, busy1, we1, addr1, wd1}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", {ack0, busy0, ack1, busy1}, 0);

        run(16'd12800, 8'd25);
        chk("t1_const", {8'd0, res0()}, 32'h020000);
        run(16'd2, 8'd3);
        chk("t2_trunc", {8'd0, res0()}, 32'h0000AA);
        chk("t2_round", {8'd0, res1()}, 32'h0000AB);
        run(16'hFFFF, 8'd1);
        chk("t3_max", {8'd0, res1()}, 32'hFFFF00);
        run(16'd0, 8'd7);
        chk("t3_zero", {8'd0, res0()}, 32'h000000);
        run(16'd1234, 8'd0);
        chk("t4_sat", {8'd0, res0()}, 32'hFFFFFF);
        run(16'hFFFF, 8'd255);
        run(16'd1, 8'd255);

        // Abort mid-divide: no writes, no Ack, result area untouched.
        @(negedge clk);
        preload(16'd1000, 8'd7);
        repeat (2) @(negedge clk);
        wr0 = 0;
        wr1 = 0;
        start = 1'b0;
        @(posedge clk);
        repeat (13) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_idle", {ack0, busy0, ack1, busy1}, 0);
        chk("abort_wr", wr0 + wr1, 0);
        chk("abort_mem0", {8'd0, res0()}, 32'hA5A5A5);
        chk("abort_mem1", {8'd0, res1()}, 32'hA5A5A5);
        run(16'd1000, 8'd7);

        // Async reset while in WR1 of a zero-divisor run.
        @(negedge clk);
        preload(16'd1234, 8'd0);
        repeat (2) @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        chk("wr1_state", {we0, addr0, we1, addr1}, {1'b1, 8'd5, 1'b1, 8'd5});
        rst_n = 1'b0;
        #1;
        chk("rst_async0", {ack0, busy0, we0, addr0, wd0}, 0);
        chk("rst_async1", {ack1, busy1, we1, addr1, wd1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mem0", {8'd0, res0()}, 32'hFFA5A5);
        chk("rst_mem1", {8'd0, res1()}, 32'hFFA5A5);
        run(16'd1234, 8'd0);
        run(16'd40000, 8'd3);

        for (int i = 0; i < 200; i++) begin
            logic [15:0] dvd;
            logic [7:0]  dvs;
            dvd = 16'($urandom);
            dvs = 8'($urandom_range(0, 255));
            run(dvd, dvs);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
